// File: rtl/tcdm_to_axi_bridge.sv
// TCDM/LINT master port to 32-bit AXI4 master, single beat per access.
// One transaction in flight; the TCDM response pulses the cycle after the B or R handshake.
module tcdm_to_axi_bridge #(
   parameter int unsigned AXI_ID_WIDTH   = 1,
   parameter int unsigned AXI_USER_WIDTH = 6,
   parameter int unsigned AXI_ID_VALUE   = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,

   input  logic                      tcdm_req_i,
   input  logic [31:0]               tcdm_add_i,
   input  logic                      tcdm_wen_i,
   input  logic [31:0]               tcdm_wdata_i,
   input  logic [3:0]                tcdm_be_i,
   output logic                      tcdm_gnt_o,
   output logic                      tcdm_r_valid_o,
   output logic [31:0]               tcdm_r_rdata_o,
   output logic                      tcdm_r_opc_o,

   output logic                      aw_valid_o,
   input  logic                      aw_ready_i,
   output logic [31:0]               aw_addr_o,
   output logic [AXI_ID_WIDTH-1:0]   aw_id_o,
   output logic [7:0]                aw_len_o,
   output logic [2:0]                aw_size_o,
   output logic [1:0]                aw_burst_o,
   output logic [AXI_USER_WIDTH-1:0] aw_user_o,
   output logic                      aw_lock_o,
   output logic [3:0]                aw_cache_o,
   output logic [2:0]                aw_prot_o,
   output logic [3:0]                aw_qos_o,
   output logic [3:0]                aw_region_o,
   output logic [5:0]                aw_atop_o,

   output logic                      w_valid_o,
   input  logic                      w_ready_i,
   output logic [31:0]               w_data_o,
   output logic [3:0]                w_strb_o,
   output logic                      w_last_o,
   output logic [AXI_USER_WIDTH-1:0] w_user_o,

   input  logic                      b_valid_i,
   output logic                      b_ready_o,
   input  logic [1:0]                b_resp_i,
   input  logic [AXI_ID_WIDTH-1:0]   b_id_i,

   output logic                      ar_valid_o,
   input  logic                      ar_ready_i,
   output logic [31:0]               ar_addr_o,
   output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
   output logic [7:0]                ar_len_o,
   output logic [2:0]                ar_size_o,
   output logic [1:0]                ar_burst_o,
   output logic [AXI_USER_WIDTH-1:0] ar_user_o,
   output logic                      ar_lock_o,
   output logic [3:0]                ar_cache_o,
   output logic [2:0]                ar_prot_o,
   output logic [3:0]                ar_qos_o,
   output logic [3:0]                ar_region_o,

   input  logic                      r_valid_i,
   output logic                      r_ready_o,
   input  logic [31:0]               r_data_i,
   input  logic [1:0]                r_resp_i,
   input  logic                      r_last_i,
   input  logic [AXI_ID_WIDTH-1:0]   r_id_i
);

   localparam logic [AXI_ID_WIDTH-1:0] LP_ID         = AXI_ID_WIDTH'(AXI_ID_VALUE);
   localparam logic [2:0]              LP_SIZE_4B    = 3'b010;
   localparam logic [1:0]              LP_BURST_INCR = 2'b01;
   localparam logic [1:0]              LP_RESP_EXOK  = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WR_RESP,
      S_READ,
      S_RD_RESP
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_aw_done;
   logic        r_w_done;
   logic        r_rsp_valid;
   logic        r_rsp_opc;
   logic [31:0] r_rdata;

   logic        w_gnt;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_b_hs;
   logic        w_ar_hs;
   logic        w_r_hs;

   assign w_gnt      = tcdm_req_i && (r_state == S_IDLE);
   assign aw_valid_o = (r_state == S_WRITE) && !r_aw_done;
   assign w_valid_o  = (r_state == S_WRITE) && !r_w_done;
   assign ar_valid_o = (r_state == S_READ);
   assign b_ready_o  = (r_state == S_WR_RESP);
   assign r_ready_o  = (r_state == S_RD_RESP);

   assign w_aw_hs = aw_valid_o && aw_ready_i;
   assign w_w_hs  = w_valid_o && w_ready_i;
   assign w_ar_hs = ar_valid_o && ar_ready_i;
   assign w_b_hs  = b_valid_i && b_ready_o;
   assign w_r_hs  = r_valid_i && r_ready_o;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assigned first so no branch leaves the signal unassigned (no latch).
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_gnt) w_state_nxt = tcdm_wen_i ? S_READ : S_WRITE;
         end
         S_WRITE: begin
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = S_WR_RESP;
         end
         S_WR_RESP: begin
            if (b_valid_i) w_state_nxt = S_IDLE;
         end
         S_READ: begin
            if (ar_ready_i) w_state_nxt = S_RD_RESP;
         end
         S_RD_RESP: begin
            if (r_valid_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Request is captured on grant; AW and W complete independently while in WRITE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (w_gnt) begin
         r_addr    <= tcdm_add_i;
         r_wdata   <= tcdm_wdata_i;
         r_be      <= tcdm_be_i;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
      end
   end

   // Read data is only refreshed by R beats, so it holds across writes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rsp_valid <= 1'b0;
         r_rsp_opc   <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_rsp_valid <= w_b_hs || w_r_hs;
         if (w_b_hs) begin
            r_rsp_opc <= b_resp_i[1];
         end else if (w_r_hs) begin
            r_rsp_opc <= r_resp_i[1];
            r_rdata   <= r_data_i;
         end
      end
   end

   assign tcdm_gnt_o     = w_gnt;
   assign tcdm_r_valid_o = r_rsp_valid;
   assign tcdm_r_opc_o   = r_rsp_opc;
   assign tcdm_r_rdata_o = r_rdata;

   assign aw_addr_o   = r_addr;
   assign aw_id_o     = LP_ID;
   assign aw_len_o    = 8'd0;
   assign aw_size_o   = LP_SIZE_4B;
   assign aw_burst_o  = LP_BURST_INCR;
   assign aw_user_o   = '0;
   assign aw_lock_o   = 1'b0;
   assign aw_cache_o  = 4'd0;
   assign aw_prot_o   = 3'd0;
   assign aw_qos_o    = 4'd0;
   assign aw_region_o = 4'd0;
   assign aw_atop_o   = 6'd0;

   assign w_data_o = r_wdata;
   assign w_strb_o = r_be;
   assign w_last_o = 1'b1;
   assign w_user_o = '0;

   assign ar_addr_o   = r_addr;
   assign ar_id_o     = LP_ID;
   assign ar_len_o    = 8'd0;
   assign ar_size_o   = LP_SIZE_4B;
   assign ar_burst_o  = LP_BURST_INCR;
   assign ar_user_o   = '0;
   assign ar_lock_o   = 1'b0;
   assign ar_cache_o  = 4'd0;
   assign ar_prot_o   = 3'd0;
   assign ar_qos_o    = 4'd0;
   assign ar_region_o = 4'd0;

   // Responses outside their state are dropped by the datapath; these flag the violation.
   a_b_in_wr_resp: assert property (@(posedge clk_i) disable iff (rst_i)
      b_valid_i |-> (r_state == S_WR_RESP));
   a_r_in_rd_resp: assert property (@(posedge clk_i) disable iff (rst_i)
      r_valid_i |-> (r_state == S_RD_RESP));
   a_b_fields: assert property (@(posedge clk_i) disable iff (rst_i)
      w_b_hs |-> (b_id_i == LP_ID) && (b_resp_i != LP_RESP_EXOK));
   a_r_fields: assert property (@(posedge clk_i) disable iff (rst_i)
      w_r_hs |-> r_last_i && (r_id_i == LP_ID) && (r_resp_i != LP_RESP_EXOK));

endmodule
